fp_div: RTL

Iterative floating-point divider for the 24-bit shader float format (sign[23], exponent[22:15] bias 127, mantissa[14:0] with implicit leading 1). Computes a / b using restoring division at one quotient bit per cycle, behind valid/ready handshakes on both sides. It is the inverse-operation companion to the combinational multiplier: same format, same flush-to-zero and truncation rules. It sits beside the multiplier in the shader ALU for reciprocal and divide operations.

---
 rtl/fp_div.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fp_div.sv
// fp_div: iterative divider for the 24-bit shader float format
//   sign[23], exponent[22:15] (bias 127), mantissa[14:0] with an implicit 1.
//   Computes a / b by restoring division, one quotient bit per cycle
//   (17 iterations), behind valid/ready handshakes on input and output.
//   Zero exponent means zero (flush-to-zero); results are truncated.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operands a_i / b_i valid
//   in_ready_o   divider idle and can accept
//   a_i, b_i     dividend, divisor
//   out_valid_o  result valid, held until accepted
//   out_ready_i  consumer accepts result
//   result_o     quotient
//   dbz_o        divide-by-zero flag, qualified by out_valid_o
//   ovf_o        exponent overflow flag, qualified by out_valid_o
module fp_div #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             dbz_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  localparam logic [4:0] LAST_ITER = 5'd16;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [7:0]         ea_q, ea_d;
  logic [7:0]         eb_q, eb_d;
  logic [17:0]        rem_q, rem_d;
  logic [15:0]        dvs_q, dvs_d;
  logic [16:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  // One restoring-division step. The remainder stays below 2*D, so the
  // shifted value always fits in 18 bits.
  logic [17:0]        rem_sub;
  logic               rem_ge;
  logic [17:0]        rem_step;
  logic [16:0]        quo_step;

  // Normalisation of the quotient after the final step. Q[16] has weight 2^0.
  logic signed [9:0]  exp_res;
  logic [14:0]        mant_res;

  logic               a_zero, b_zero;

  always_comb begin
    rem_sub  = rem_q - {2'b00, dvs_q};
    rem_ge   = (rem_q >= {2'b00, dvs_q});
    rem_step = rem_ge ? (rem_sub << 1) : (rem_q << 1);
    quo_step = {quo_q[15:0], rem_ge};

    // 10-bit signed so both underflow (<= 0) and overflow (>= 255) are visible.
    exp_res  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
             + (quo_step[16] ? 10'sd127 : 10'sd126);
    mant_res = quo_step[16] ? quo_step[15:1] : quo_step[14:0];

    a_zero = (a_i[22:15] == 8'h00);
    b_zero = (b_i[22:15] == 8'h00);
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first (hold value), so no
    // path through the case leaves a signal unassigned and infers a latch.
    state_d  = state_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sign_d = a_i[23] ^ b_i[23];
          ea_d   = a_i[22:15];
          eb_d   = b_i[22:15];
          rem_d  = {2'b01, a_i[14:0]};
          dvs_d  = {1'b1, b_i[14:0]};
          quo_d  = '0;
          cnt_d  = '0;
          if (b_zero) begin
            // Divisor zero wins over a zero dividend, so 0/0 also reports dbz.
            result_d = {a_i[23] ^ b_i[23], 8'hFF, 15'h0000};
            dbz_d    = 1'b1;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end else if (a_zero) begin
            result_d = '0;
            dbz_d    = 1'b0;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end else begin
            state_d  = DIV;
          end
        end
      end

      DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          dbz_d = 1'b0;
          if (exp_res <= 10'sd0) begin
            result_d = '0;
            ovf_d    = 1'b0;
          end else if (exp_res >= 10'sd255) begin
            result_d = {sign_q, 8'hFE, 15'h7FFF};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_res[7:0], mant_res};
            ovf_d    = 1'b0;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;
  assign dbz_o       = dbz_q;
  assign ovf_o       = ovf_q;

endmodule
